// File: rtl/riscv_ex_mem_reg_if.sv
// EX/MEM stage bundle: EX-side inputs, MEM-side outputs, redirect and forwarding.
// The EX side is the master; the pipeline register itself takes the slave view.
interface riscv_ex_mem_reg_if #(
    parameter int XLEN = 32
);
    logic            stall;
    logic            flush;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_imm;
    logic            alu_zero;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] ex_rs2_data;
    logic [4:0]      ex_rd;
    logic [2:0]      ex_funct3;
    logic            ex_reg_wr;
    logic            ex_mem_rd;
    logic            ex_mem_wr;
    logic            ex_branch;
    logic            ex_jal;
    logic            ex_jalr;

    logic            mem_valid;
    logic [XLEN-1:0] mem_result;
    logic [XLEN-1:0] mem_wdata;
    logic [3:0]      mem_wstrb;
    logic [4:0]      mem_rd;
    logic [2:0]      mem_funct3;
    logic            mem_reg_wr;
    logic            mem_mem_rd;
    logic            mem_mem_wr;
    logic            misalign;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            fwd_valid;
    logic [4:0]      fwd_rd;
    logic [XLEN-1:0] fwd_data;

    modport master (
        output stall, flush, ex_valid, ex_pc, ex_imm, alu_zero, alu_result,
               ex_rs2_data, ex_rd, ex_funct3, ex_reg_wr, ex_mem_rd, ex_mem_wr,
               ex_branch, ex_jal, ex_jalr,
        input  mem_valid, mem_result, mem_wdata, mem_wstrb, mem_rd, mem_funct3,
               mem_reg_wr, mem_mem_rd, mem_mem_wr, misalign, redirect,
               redirect_pc, fwd_valid, fwd_rd, fwd_data
    );

    modport slave (
        input  stall, flush, ex_valid, ex_pc, ex_imm, alu_zero, alu_result,
               ex_rs2_data, ex_rd, ex_funct3, ex_reg_wr, ex_mem_rd, ex_mem_wr,
               ex_branch, ex_jal, ex_jalr,
        output mem_valid, mem_result, mem_wdata, mem_wstrb, mem_rd, mem_funct3,
               mem_reg_wr, mem_mem_rd, mem_mem_wr, misalign, redirect,
               redirect_pc, fwd_valid, fwd_rd, fwd_data
    );
endinterface

// File: rtl/riscv_ex_mem_reg.sv
// RV32I EX/MEM pipeline register: branch/jump resolution, store lane alignment, stall/flush.
// Optional MEM-stage forwarding port enabled by defining RISCV_EXMEM_FWD_EN.
module riscv_ex_mem_reg #(
    parameter int XLEN = 32
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    riscv_ex_mem_reg_if.slave   bus
);
    logic [1:0]      size_c;
    logic [1:0]      addr_lo_c;
    logic            mem_access_c;
    logic            misalign_c;
    logic            cond_c;
    logic            br_taken_c;
    logic            redirect_c;
    logic [XLEN-1:0] target_c;
    logic [XLEN-1:0] link_c;
    logic [XLEN-1:0] result_c;
    logic [XLEN-1:0] wdata_c;
    logic [3:0]      lane_strb_c;
    logic [3:0]      wstrb_c;
    logic            load_bubble;
    logic            load_real;

    logic            valid_q;
    logic [XLEN-1:0] result_q;
    logic [XLEN-1:0] wdata_q;
    logic [3:0]      wstrb_q;
    logic [4:0]      rd_q;
    logic [2:0]      funct3_q;
    logic            reg_wr_q;
    logic            mem_rd_q;
    logic            mem_wr_q;
    logic            misalign_q;
    logic            redirect_q;
    logic [XLEN-1:0] redirect_pc_q;

    assign size_c       = bus.ex_funct3[1:0];
    assign addr_lo_c    = bus.alu_result[1:0];
    assign mem_access_c = bus.ex_mem_rd | bus.ex_mem_wr;
    assign misalign_c   = mem_access_c &
                          (((size_c == 2'b01) & addr_lo_c[0]) |
                           ((size_c == 2'b10) & (addr_lo_c != 2'b00)));

    // Signed/unsigned compares arrive from the ALU as a set-less-than in result[0].
    always_comb begin
        cond_c = 1'b0;
        case (bus.ex_funct3)
            3'b000:          cond_c = bus.alu_zero;
            3'b001:          cond_c = ~bus.alu_zero;
            3'b100, 3'b110:  cond_c = bus.alu_result[0];
            3'b101, 3'b111:  cond_c = ~bus.alu_result[0];
            default:         cond_c = 1'b0;
        endcase
    end

    assign br_taken_c = bus.ex_branch & cond_c;
    assign redirect_c = br_taken_c | bus.ex_jal | bus.ex_jalr;
    assign target_c   = bus.ex_jalr ? {bus.alu_result[XLEN-1:1], 1'b0}
                                    : bus.ex_pc + bus.ex_imm;
    assign link_c     = bus.ex_pc + XLEN'(4);
    assign result_c   = (bus.ex_jal | bus.ex_jalr) ? link_c : bus.alu_result;

    always_comb begin
        wdata_c     = bus.ex_rs2_data;
        lane_strb_c = 4'b0000;
        case (size_c)
            2'b00: begin
                wdata_c     = {4{bus.ex_rs2_data[7:0]}};
                lane_strb_c = 4'b0001 << addr_lo_c;
            end
            2'b01: begin
                wdata_c     = {2{bus.ex_rs2_data[15:0]}};
                lane_strb_c = 4'b0011 << addr_lo_c;
            end
            2'b10: begin
                wdata_c     = bus.ex_rs2_data;
                lane_strb_c = 4'b1111;
            end
            default: begin
                wdata_c     = bus.ex_rs2_data;
                lane_strb_c = 4'b0000;
            end
        endcase
    end

    assign wstrb_c = (bus.ex_mem_wr & ~misalign_c) ? lane_strb_c : 4'b0000;

    // Flush wins over stall; an invalid EX slot captured without stall is a bubble.
    assign load_bubble = bus.flush | (~bus.stall & ~bus.ex_valid);
    assign load_real   = ~bus.flush & ~bus.stall & bus.ex_valid;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            valid_q       <= 1'b0;
            result_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= 4'b0000;
            rd_q          <= 5'd0;
            funct3_q      <= 3'd0;
            reg_wr_q      <= 1'b0;
            mem_rd_q      <= 1'b0;
            mem_wr_q      <= 1'b0;
            misalign_q    <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            // The pulse drops after one cycle even while stalled.
            redirect_q <= load_real & redirect_c;
            if (load_bubble) begin
                valid_q    <= 1'b0;
                reg_wr_q   <= 1'b0;
                mem_rd_q   <= 1'b0;
                mem_wr_q   <= 1'b0;
                wstrb_q    <= 4'b0000;
                misalign_q <= 1'b0;
            end else if (load_real) begin
                valid_q    <= 1'b1;
                result_q   <= result_c;
                wdata_q    <= wdata_c;
                wstrb_q    <= wstrb_c;
                rd_q       <= bus.ex_rd;
                funct3_q   <= bus.ex_funct3;
                reg_wr_q   <= bus.ex_reg_wr & ~bus.ex_branch & ~misalign_c;
                mem_rd_q   <= bus.ex_mem_rd & ~misalign_c;
                mem_wr_q   <= bus.ex_mem_wr & ~misalign_c;
                misalign_q <= misalign_c;
                if (redirect_c) begin
                    redirect_pc_q <= target_c;
                end
            end
        end
    end

    assign bus.mem_valid   = valid_q;
    assign bus.mem_result  = result_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.mem_wstrb   = wstrb_q;
    assign bus.mem_rd      = rd_q;
    assign bus.mem_funct3  = funct3_q;
    assign bus.mem_reg_wr  = reg_wr_q;
    assign bus.mem_mem_rd  = mem_rd_q;
    assign bus.mem_mem_wr  = mem_wr_q;
    assign bus.misalign    = misalign_q;
    assign bus.redirect    = redirect_q;
    assign bus.redirect_pc = redirect_pc_q;

`ifdef RISCV_EXMEM_FWD_EN
    // Loads are excluded: their data is not known until after MEM.
    assign bus.fwd_valid = valid_q & reg_wr_q & (rd_q != 5'd0) & ~mem_rd_q;
    assign bus.fwd_rd    = rd_q;
    assign bus.fwd_data  = result_q;
`else
    assign bus.fwd_valid = 1'b0;
    assign bus.fwd_rd    = 5'd0;
    assign bus.fwd_data  = '0;
`endif

endmodule

// File: tb/tb_riscv_ex_mem_reg.sv
// Bench for riscv_ex_mem_reg: directed cases plus randomized traffic against a
// cycle-level reference model of the stage outputs.
module tb_riscv_ex_mem_reg;
    logic clk;
    logic rstn;
    int   checks;
    int   failures;

    riscv_ex_mem_reg_if #(.XLEN(32)) bus ();

    riscv_ex_mem_reg #(.XLEN(32)) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        e_valid, e_reg_wr, e_mem_rd, e_mem_wr, e_mis, e_redir;
    logic [31:0] e_result, e_wdata, e_rpc;
    logic [3:0]  e_wstrb;
    logic [4:0]  e_rd;
    logic [2:0]  e_funct3;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        e_valid = 0; e_reg_wr = 0; e_mem_rd = 0; e_mem_wr = 0; e_mis = 0; e_redir = 0;
        e_result = 0; e_wdata = 0; e_rpc = 0; e_wstrb = 0; e_rd = 0; e_funct3 = 0;
    endtask

    task automatic predict();
        int unsigned sz, a;
        logic mis, cond;
        if (bus.flush || (!bus.stall && !bus.ex_valid)) begin
            e_valid = 0; e_reg_wr = 0; e_mem_rd = 0; e_mem_wr = 0; e_redir = 0; e_wstrb = 0;
        end else if (bus.stall) begin
            e_redir = 0;
        end else begin
            sz  = bus.ex_funct3 % 4;
            a   = bus.alu_result % 4;
            mis = (bus.ex_mem_rd || bus.ex_mem_wr) &&
                  ((sz == 1 && (a % 2) == 1) || (sz == 2 && a != 0));
            case (bus.ex_funct3)
                0: cond = bus.alu_zero;
                1: cond = !bus.alu_zero;
                4, 6: cond = bus.alu_result % 2 == 1;
                5, 7: cond = bus.alu_result % 2 == 0;
                default: cond = 0;
            endcase
            e_valid  = 1;
            e_rd     = bus.ex_rd;
            e_funct3 = bus.ex_funct3;
            e_mis    = mis;
            e_result = (bus.ex_jal || bus.ex_jalr) ? bus.ex_pc + 4 : bus.alu_result;
            if (sz == 0)      e_wdata = (bus.ex_rs2_data % 256) * 32'h01010101;
            else if (sz == 1) e_wdata = (bus.ex_rs2_data % 65536) * 32'h00010001;
            else              e_wdata = bus.ex_rs2_data;
            if (!bus.ex_mem_wr || mis) e_wstrb = 0;
            else if (sz == 0)          e_wstrb = 4'(1 << a);
            else if (sz == 1)          e_wstrb = 4'(3 << a);
            else if (sz == 2)          e_wstrb = 4'hF;
            else                       e_wstrb = 0;
            e_reg_wr = bus.ex_reg_wr && !bus.ex_branch && !mis;
            e_mem_rd = bus.ex_mem_rd && !mis;
            e_mem_wr = bus.ex_mem_wr && !mis;
            e_redir  = (bus.ex_branch && cond) || bus.ex_jal || bus.ex_jalr;
            if (bus.ex_jalr)  e_rpc = bus.alu_result - (bus.alu_result % 2);
            else if (e_redir) e_rpc = bus.ex_pc + bus.ex_imm;
        end
    endtask

    task automatic check_model();
        logic fv;
        chk("valid", 32'(bus.mem_valid), 32'(e_valid));
        chk("reg_wr", 32'(bus.mem_reg_wr), 32'(e_reg_wr));
        chk("mem_rd", 32'(bus.mem_mem_rd), 32'(e_mem_rd));
        chk("mem_wr", 32'(bus.mem_mem_wr), 32'(e_mem_wr));
        chk("wstrb", 32'(bus.mem_wstrb), 32'(e_wstrb));
        chk("redirect", 32'(bus.redirect), 32'(e_redir));
        if (e_valid) begin
            chk("result", bus.mem_result, e_result);
            chk("rd", 32'(bus.mem_rd), 32'(e_rd));
            chk("funct3", 32'(bus.mem_funct3), 32'(e_funct3));
            chk("misalign", 32'(bus.misalign), 32'(e_mis));
            if (e_mem_wr) chk("wdata", bus.mem_wdata, e_wdata);
        end
        if (e_redir) chk("redirect_pc", bus.redirect_pc, e_rpc);
`ifdef RISCV_EXMEM_FWD_EN
        fv = e_valid && e_reg_wr && e_rd != 0 && !e_mem_rd;
        chk("fwd_valid", 32'(bus.fwd_valid), 32'(fv));
        if (fv) begin
            chk("fwd_rd", 32'(bus.fwd_rd), 32'(e_rd));
            chk("fwd_data", bus.fwd_data, e_result);
        end
`else
        fv = 1'b0;
        chk("fwd_valid_tied", 32'(bus.fwd_valid), 32'(fv));
        chk("fwd_data_tied", bus.fwd_data, 32'h0);
`endif
    endtask

    task automatic check_zero(input string tag);
        logic [31:0] acc;
        acc = 32'(bus.mem_valid) | bus.mem_result | bus.mem_wdata | 32'(bus.mem_wstrb) |
              32'(bus.mem_rd) | 32'(bus.mem_funct3) | 32'(bus.mem_reg_wr) |
              32'(bus.mem_mem_rd) | 32'(bus.mem_mem_wr) | 32'(bus.misalign) |
              32'(bus.redirect) | bus.redirect_pc | 32'(bus.fwd_valid) |
              32'(bus.fwd_rd) | bus.fwd_data;
        chk(tag, acc, 32'h0);
        chk({tag, "_valid"}, 32'(bus.mem_valid), 32'h0);
        chk({tag, "_redirect"}, 32'(bus.redirect), 32'h0);
    endtask

    task automatic tick();
        predict();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] imm,
                         input logic zero, input logic [31:0] alu, input logic [31:0] rs2,
                         input logic [4:0] rd, input logic [2:0] f3, input logic rw,
                         input logic mr, input logic mw, input logic br, input logic jal,
                         input logic jalr);
        bus.ex_valid = v; bus.ex_pc = pc; bus.ex_imm = imm; bus.alu_zero = zero;
        bus.alu_result = alu; bus.ex_rs2_data = rs2; bus.ex_rd = rd; bus.ex_funct3 = f3;
        bus.ex_reg_wr = rw; bus.ex_mem_rd = mr; bus.ex_mem_wr = mw;
        bus.ex_branch = br; bus.ex_jal = jal; bus.ex_jalr = jalr;
    endtask

    task automatic drive_random();
        int unsigned kind;
        logic [31:0] alu;
        logic [2:0]  f3;
        kind = $urandom_range(0, 5);
        alu  = $urandom;
        f3   = 3'($urandom_range(0, 7));
        case (kind)
            0: drive(1, $urandom, $urandom, $urandom_range(0, 1) == 1, alu, $urandom,
                     5'($urandom), f3, 1, 0, 0, 0, 0, 0);
            1: drive(1, $urandom, $urandom, 0, alu, $urandom, 5'($urandom),
                     {1'($urandom), 2'($urandom_range(0, 2))}, 1, 1, 0, 0, 0, 0);
            2: drive(1, $urandom, $urandom, 0, alu, $urandom, 5'($urandom),
                     {1'b0, 2'($urandom_range(0, 2))}, 0, 0, 1, 0, 0, 0);
            3: drive(1, $urandom, $urandom, $urandom_range(0, 1) == 1, alu, $urandom,
                     5'($urandom), f3, $urandom_range(0, 1) == 1, 0, 0, 1, 0, 0);
            4: drive(1, $urandom, $urandom, 0, alu, $urandom, 5'($urandom), 3'd0,
                     1, 0, 0, 0, 1, 0);
            default: drive(1, $urandom, $urandom, 0, alu, $urandom, 5'($urandom), 3'd0,
                           1, 0, 0, 0, 0, 1);
        endcase
        bus.ex_valid = $urandom_range(0, 99) < 85;
        bus.stall    = $urandom_range(0, 99) < 20;
        bus.flush    = $urandom_range(0, 99) < 10;
    endtask

    initial begin
        int redir_cnt;
        logic [31:0] held_result;
        checks = 0;
        failures = 0;
        model_clear();
        rstn = 1'b0;
        bus.stall = 0;
        bus.flush = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_state");
        @(negedge clk);
        rstn = 1'b1;

        // BEQ taken; asserted reg_wr must be suppressed
        drive(1, 32'h100, 32'h20, 1, 32'h0, 32'h0, 5'd3, 3'b000, 1, 0, 0, 1, 0, 0);
        tick();
        chk("beq_redirect", 32'(bus.redirect), 32'h1);
        chk("beq_target", bus.redirect_pc, 32'h120);
        chk("beq_reg_wr", 32'(bus.mem_reg_wr), 32'h0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("beq_pulse_end", 32'(bus.redirect), 32'h0);

        drive(1, 32'h140, 32'h40, 0, 32'h1, 0, 0, 3'b111, 0, 0, 0, 1, 0, 0);
        tick();
        chk("bgeu_not_taken", 32'(bus.redirect), 32'h0);

        drive(1, 32'h200, 32'h0, 0, 32'h1235, 0, 5'd1, 3'b000, 1, 0, 0, 0, 0, 1);
        tick();
        chk("jalr_target", bus.redirect_pc, 32'h1234);
        chk("jalr_link", bus.mem_result, 32'h204);

        drive(1, 32'h210, 0, 0, 32'h1003, 32'h000000A5, 0, 3'b000, 0, 0, 1, 0, 0, 0);
        tick();
        chk("sb_wstrb", 32'(bus.mem_wstrb), 32'h8);
        chk("sb_wdata", bus.mem_wdata, 32'hA5A5A5A5);

        drive(1, 32'h214, 0, 0, 32'h1001, 32'h00001234, 0, 3'b001, 0, 0, 1, 0, 0, 0);
        tick();
        chk("sh_misalign", 32'(bus.misalign), 32'h1);
        chk("sh_mem_wr", 32'(bus.mem_mem_wr), 32'h0);
        chk("sh_wstrb", 32'(bus.mem_wstrb), 32'h0);

        // BNE taken with wrapping add, then a 3-cycle stall
        drive(1, 32'h300, 32'hFFFFFFF0, 0, 32'h5, 0, 0, 3'b001, 0, 0, 0, 1, 0, 0);
        tick();
        chk("bne_target", bus.redirect_pc, 32'h2F0);
        redir_cnt = 32'(bus.redirect);
        held_result = bus.mem_result;
        for (int i = 0; i < 3; i++) begin
            drive_random();
            bus.stall = 1;
            bus.flush = 0;
            tick();
            redir_cnt += 32'(bus.redirect);
        end
        chk("stall_single_pulse", 32'(redir_cnt), 32'h1);
        chk("stall_hold_result", bus.mem_result, held_result);
        chk("stall_hold_valid", 32'(bus.mem_valid), 32'h1);

        drive(1, 32'h320, 0, 0, 32'h77, 0, 5'd9, 3'b000, 1, 0, 0, 0, 0, 0);
        bus.stall = 1;
        bus.flush = 1;
        tick();
        chk("stall_flush_valid", 32'(bus.mem_valid), 32'h0);
        chk("stall_flush_reg_wr", 32'(bus.mem_reg_wr), 32'h0);
        bus.stall = 0;
        bus.flush = 0;

        drive(1, 32'h400, 0, 0, 32'h10, 0, 5'd5, 3'b000, 1, 0, 0, 0, 0, 0);
        tick();
`ifdef RISCV_EXMEM_FWD_EN
        chk("fwd_add_valid", 32'(bus.fwd_valid), 32'h1);
        chk("fwd_add_rd", 32'(bus.fwd_rd), 32'h5);
        chk("fwd_add_data", bus.fwd_data, 32'h10);
`else
        chk("fwd_off_valid", 32'(bus.fwd_valid), 32'h0);
`endif
        drive(1, 32'h404, 0, 0, 32'h10, 0, 5'd0, 3'b000, 1, 0, 0, 0, 0, 0);
        tick();
        chk("fwd_x0", 32'(bus.fwd_valid), 32'h0);
        drive(1, 32'h408, 0, 0, 32'h20, 0, 5'd5, 3'b010, 1, 1, 0, 0, 0, 0);
        tick();
        chk("fwd_load", 32'(bus.fwd_valid), 32'h0);

        // JAL then asynchronous reset between clock edges
        drive(1, 32'h500, 32'h8, 0, 32'h0, 0, 5'd1, 3'b000, 1, 0, 0, 0, 1, 0);
        tick();
        chk("jal_redirect", 32'(bus.redirect), 32'h1);
        chk("jal_valid", 32'(bus.mem_valid), 32'h1);
        chk("jal_target", bus.redirect_pc, 32'h508);
        #2;
        rstn = 1'b0;
        #1;
        check_zero("async_reset");
        model_clear();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rstn = 1'b1;

        for (int n = 0; n < 400; n++) begin
            drive_random();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/riscv_ex_mem_reg.md
Name: riscv_ex_mem_reg

Overview:
EX/MEM pipeline stage of the RV32I core. It sits directly downstream of the ALU and consumes its result and zero flag together with the EX-stage control bundle. It resolves conditional branches and jumps into a registered PC redirect, and aligns store data and byte strobes for the data-memory port. It registers everything for the MEM stage, with stall (hold) and flush (bubble) control.

Parameters:
XLEN, 32, datapath width; only 32 is supported (byte-lane logic assumes 4 lanes)

Ports:
i_clk  in  1  core clock, rising edge
i_rstn  in  1  asynchronous active-low reset
i_stall  in  1  hold all stage registers
i_flush  in  1  kill the instruction entering this cycle
i_ex_valid  in  1  EX slot holds a real instruction
i_ex_pc  in  XLEN  PC of EX instruction
i_ex_imm  in  XLEN  sign-extended immediate
i_alu_zero  in  1  ALU zero flag
i_alu_result  in  XLEN  ALU result
i_ex_rs2_data  in  XLEN  store source data
i_ex_rd  in  5  destination register
i_ex_funct3  in  3  branch condition / load-store size
i_ex_reg_wr, i_ex_mem_rd, i_ex_mem_wr, i_ex_branch, i_ex_jal, i_ex_jalr  in  1 each  control bits
o_mem_valid  out  1  MEM slot valid
o_mem_result  out  XLEN  ALU result, or PC+4 for JAL/JALR
o_mem_wdata  out  XLEN  lane-replicated store data
o_mem_wstrb  out  4  byte write strobes
o_mem_rd  out  5  destination register
o_mem_funct3  out  3  registered funct3
o_mem_reg_wr, o_mem_mem_rd, o_mem_mem_wr  out  1 each  registered control
o_misalign  out  1  registered misaligned-access flag
o_redirect  out  1  one-cycle redirect pulse
o_redirect_pc  out  XLEN  redirect target
o_fwd_valid, o_fwd_rd, o_fwd_data  out  1/5/XLEN  forwarding (optional feature)

Behaviour:
- Reset (async, i_rstn=0): every output is 0. Registers are released on the first rising edge after deassertion.
- Capture: on each rising edge with i_stall=0, the stage registers load the EX bundle. Latency is 1 cycle.
- Stall (i_stall=1, i_flush=0): all registers hold. o_redirect clears after its one cycle regardless of stall, so there is never a duplicate pulse.
- Flush has priority over stall. On an edge with i_flush=1, the stage loads a bubble: valid, reg_wr, mem_rd, mem_wr and redirect all 0; data fields are don't-care (implement as hold).
- i_ex_valid=0 is treated exactly as a bubble.
- Branch taken, by funct3:
  - 000 BEQ: zero
  - 001 BNE: !zero
  - 100 BLT / 110 BLTU: result[0]
  - 101 BGE / 111 BGEU: !result[0]
  - 010 / 011: never taken
- Redirect targets:
  - taken branch or JAL: pc+imm
  - JALR: alu_result with bit0 forced to 0
- o_redirect=1 and o_redirect_pc are loaded only on a captured, valid, non-flushed instruction.
- o_mem_result = pc+4 when JAL or JALR, else alu_result. All adds are modulo 2^XLEN; wrap-around is silent.
- Stores, address offset a = alu_result[1:0]:
  - SB (funct3[1:0]=00): wdata = byte×4; wstrb = 0001<<a
  - SH (01): wdata = half×2; wstrb = 0011<<a
  - SW (10): wdata = rs2; wstrb = 1111
- Misaligned when SH with a[0]=1, or SW with a≠0. Applies to both loads and stores.
- On misalignment: o_misalign=1, o_mem_mem_wr=0, o_mem_mem_rd=0, o_mem_reg_wr=0, o_mem_wstrb=0.
- When not storing, o_mem_wstrb=0.
- A branch never writes a register, even if i_ex_reg_wr=1 is asserted with it.

Optional Feature:
RISCV_EXMEM_FWD_EN
- Defined: o_fwd_valid = o_mem_valid & o_mem_reg_wr & (o_mem_rd≠0) & ~o_mem_mem_rd; o_fwd_rd = o_mem_rd; o_fwd_data = o_mem_result. All combinational from stage registers.
- Undefined: the ports still exist and are tied to 0.

Test Plan:
- Reset mid-stream: assert i_rstn=0 while o_mem_valid=1 and o_redirect=1 -> all outputs 0 immediately, with no clock edge needed.
- BEQ at pc=0x100, imm=0x20, alu_zero=1 -> next cycle o_redirect=1, o_redirect_pc=0x120, o_mem_reg_wr=0; the following cycle o_redirect=0.
- BGEU with result=1 -> o_redirect=0. JALR at pc=0x200, alu_result=0x1235, rd=1 -> o_redirect_pc=0x1234, o_mem_result=0x204.
- SB with addr=0x1003, rs2=0xA5 -> wstrb=1000, wdata=0xA5A5A5A5. SH with addr=0x1001 -> o_misalign=1, mem_wr=0, wstrb=0.
- Taken branch captured, then i_stall=1 for 3 cycles -> o_redirect high exactly 1 cycle and outputs held. Stall and flush together -> bubble loaded.
- With RISCV_EXMEM_FWD_EN defined: ADD writing x5=0x10 -> o_fwd_valid=1, o_fwd_rd=5, o_fwd_data=0x10. rd=x0 or a load -> o_fwd_valid=0.
